datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
- Upstream control-word sequencer for the adder/regfile datapath.
- Holds a small program of 33-bit control words and replays them one per clock. Replay is once or looped.
- Drives ALUSrc, AddSub, RA0, RA1, WA and Im of datapath1, replacing direct per-cycle logic-analyzer driving.
- Program is loaded and started through logic-analyzer bits in the user project wrapper.

Parameters:
- DEPTH, 16: number of program words; must be a power of two, 2..64.
- AW, 4: address width; must equal log2(DEPTH).

Ports:
- i_CLK  input  1  datapath clock (same clock as datapath1).
- i_RST  input  1  reset; asynchronous, active-high.
- i_WrEn  input  1  program write strobe.
- i_WrAddr  input  AW  program write address.
- i_WrData  input  33  control word. Bit 32 ALUSrc, 31 AddSub, 30:26 RA0, 25:21 RA1, 20:16 WA, 15:0 Im.
- i_Len  input  AW+1  program length in words; sampled at start.
- i_Loop  input  1  1 = repeat program until stopped; sampled at start.
- i_Start  input  1  start request (level; acted on in IDLE/DONE only).
- i_Stop  input  1  abort request.
- o_ALUSrc  output  1  control word field.
- o_AddSub  output  1  control word field.
- o_RA0  output  5  control word field.
- o_RA1  output  5  control word field.
- o_WA  output  5  control word field.
- o_Im  output  16  control word field.
- o_Valid  output  1  current outputs carry a program word.
- o_Busy  output  1  state is RUN.
- o_Done  output  1  sticky; program completed without loop.
- o_Pass  output  8  completed passes, saturating at 255.
- o_WrErr  output  1  one-cycle pulse; write rejected because state is RUN.

Behaviour:
- Clock and reset:
  - Single clock i_CLK; reset is asynchronous and active-high on i_RST.
  - Reset values: state IDLE, pc 0. All control outputs 0, o_Valid 0, o_Busy 0, o_Done 0, o_Pass 0, o_WrErr 0.
  - Program memory is not reset.
- Program memory: DEPTH x 33 registers.
  - A write occurs on a rising edge when i_WrEn=1 and state is not RUN.
  - i_WrEn=1 while in RUN leaves memory unchanged and pulses o_WrErr the next cycle.
- States:
  - IDLE -> RUN on i_Start=1 with i_Len!=0 and i_Stop=0.
  - RUN -> DONE after the last word is issued with loop=0.
  - RUN -> IDLE on i_Stop=1.
  - DONE -> RUN on start, same conditions as from IDLE.
  - DONE -> IDLE on i_Stop=1.
- Start:
  - Latch len = min(i_Len, DEPTH) and loop = i_Loop; set pc=0; clear o_Done and o_Pass.
  - i_Start with i_Len=0 is ignored.
  - i_Start while in RUN is ignored.
- RUN, each cycle:
  - Output registers load mem[pc]; o_Valid=1; o_Busy=1.
  - Latency: start sampled at edge N; word 0 appears on outputs after edge N+1 and is used by the datapath at edge N+2.
  - Consecutive words appear on consecutive cycles, with no bubbles.
- End of pass, when pc==len-1 is issued:
  - o_Pass increments, saturating at 255.
  - loop=1: pc wraps to 0 and the next cycle issues word 0, with no gap.
  - loop=0: next state is DONE; o_Done=1 from the following cycle.
- Outside RUN (IDLE/DONE): control outputs forced to all zeros and o_Valid=0. The integrator gates datapath writes with o_Valid.
- Stop:
  - i_Stop=1 in RUN: the next edge drives outputs to zero, o_Valid=0 and state IDLE.
  - o_Done stays 0; o_Pass holds its value.
  - i_Stop and i_Start asserted together: stop wins.
- Writes in IDLE/DONE do not affect the latched len or loop.
- Reset asserted mid-run clears everything asynchronously; outputs go to zero immediately.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- When defined, adds two inputs:
  - i_StepMode (1 bit).
  - i_Step (1 bit), rising-edge detected internally.
- With i_StepMode=1 in RUN, pc advances and a new word loads only on a detected i_Step rise. Otherwise outputs hold the last word with o_Valid=0, so no datapath writes occur between steps.
- Stop and reset still act immediately.
- When not defined, the ports are absent and the sequencer free-runs as above.

Test Plan:
- Reset: assert i_RST mid-run with 3 words issued -> all outputs 0 immediately, state IDLE, o_Pass=0.
- Single pass:
  - Load words 0..3 with WA=1..4, Im=0x0010,0x0020,0x0030,0x0040.
  - Then Len=4, Loop=0, Start.
  - Expect o_Valid high for exactly 4 cycles, starting one cycle after start, with Im sequence 0x10,0x20,0x30,0x40.
  - Then o_Done=1, o_Pass=1, outputs 0.
- Loop and stop:
  - Len=2, Loop=1, run 7 cycles; expect words 0,1,0,1,0,1,0 and o_Pass=3.
  - Assert Stop; next cycle o_Valid=0, o_Done=0, o_Pass=3.
- Boundaries:
  - Start with Len=0 -> stays IDLE.
  - Len=20 with DEPTH=16 -> exactly 16 words issued.
  - Start+Stop in the same cycle -> stays IDLE.
- Write during RUN: i_WrEn at addr 0 while running -> o_WrErr pulses once; a re-run shows the original word 0.
- Saturation: Len=1, Loop=1 for 300 cycles -> o_Pass=255. With SEQ_SINGLE_STEP_EN, 3 i_Step pulses advance exactly 3 words.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Control-word sequencer for datapath1: replays a loaded program once or in a loop.
// Optional single-step mode is enabled by defining SEQ_SINGLE_STEP_EN.
module datapath_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  input  logic          i_WrEn,
  input  logic [AW-1:0] i_WrAddr,
  input  logic [32:0]   i_WrData,
  input  logic [AW:0]   i_Len,
  input  logic          i_Loop,
  input  logic          i_Start,
  input  logic          i_Stop,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic          i_StepMode,
  input  logic          i_Step,
`endif
  output logic          o_ALUSrc,
  output logic          o_AddSub,
  output logic [4:0]    o_RA0,
  output logic [4:0]    o_RA1,
  output logic [4:0]    o_WA,
  output logic [15:0]   o_Im,
  output logic          o_Valid,
  output logic          o_Busy,
  output logic          o_Done,
  output logic [7:0]    o_Pass,
  output logic          o_WrErr
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [AW:0] LenMax = (AW+1)'(DEPTH);

  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic [AW:0]   r_len, w_len_nxt;
  logic          r_loop, w_loop_nxt;
  logic [32:0]   r_word, w_word_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_done, w_done_nxt;
  logic [7:0]    r_pass, w_pass_nxt;
  logic          r_wrerr;
  logic [32:0]   r_mem [DEPTH];
  logic          w_start;
  logic          w_adv;
  logic          w_last;

`ifdef SEQ_SINGLE_STEP_EN
  logic r_step_q;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) r_step_q <= 1'b0;
    else       r_step_q <= i_Step;
  end

  // In step mode a word is issued only on a rising edge of i_Step.
  assign w_adv = !i_StepMode || (i_Step && !r_step_q);
`else
  assign w_adv = 1'b1;
`endif

  assign w_start = i_Start && !i_Stop && (i_Len != '0);
  assign w_last  = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));

  // Program memory is deliberately not reset.
  always_ff @(posedge i_CLK) begin
    if (i_WrEn && (r_state != StRun)) r_mem[i_WrAddr] <= i_WrData;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_len_nxt   = r_len;
    w_loop_nxt  = r_loop;
    w_word_nxt  = '0;
    w_valid_nxt = 1'b0;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    unique case (r_state)
      StIdle, StDone: begin
        if (r_state == StDone) w_done_nxt = 1'b1;
        if (i_Stop) begin
          w_state_nxt = StIdle;
        end else if (w_start) begin
          w_state_nxt = StRun;
          w_pc_nxt    = '0;
          w_len_nxt   = (i_Len > LenMax) ? LenMax : i_Len;
          w_loop_nxt  = i_Loop;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = '0;
        end
      end
      StRun: begin
        if (i_Stop) begin
          w_state_nxt = StIdle;
        end else if (w_adv) begin
          w_word_nxt  = r_mem[r_pc];
          w_valid_nxt = 1'b1;
          if (w_last) begin
            if (r_pass != 8'hFF) w_pass_nxt = r_pass + 8'd1;
            w_pc_nxt = '0;
            if (!r_loop) w_state_nxt = StDone;
          end else begin
            w_pc_nxt = r_pc + AW'(1);
          end
        end else begin
          // Hold the last word but mark it invalid so no datapath write happens.
          w_word_nxt = r_word;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_len   <= '0;
      r_loop  <= 1'b0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= '0;
      r_wrerr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_len   <= w_len_nxt;
      r_loop  <= w_loop_nxt;
      r_word  <= w_word_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_wrerr <= i_WrEn && (r_state == StRun);
    end
  end

  assign {o_ALUSrc, o_AddSub, o_RA0, o_RA1, o_WA, o_Im} = r_word;
  assign o_Valid = r_valid;
  assign o_Busy  = (r_state == StRun);
  assign o_Done  = r_done;
  assign o_Pass  = r_pass;
  assign o_WrErr = r_wrerr;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer against a queue/array program model.
module tb_datapath_sequencer;

  localparam int Depth = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [32:0] wr_data;
  logic [4:0]  len;
  logic        loop_en;
  logic        start;
  logic        stop;
  logic        step_mode;
  logic        step;
  logic        alusrc, addsub;
  logic [4:0]  ra0, ra1, wa;
  logic [15:0] im;
  logic        valid, busy, done, wrerr;
  logic [7:0]  pass;

  int total = 0;
  int bad   = 0;
  logic [32:0] mdl_mem [Depth];

  datapath_sequencer #(.DEPTH(16), .AW(4)) dut (
    .i_CLK      (clk),
    .i_RST      (rst),
    .i_WrEn     (wr_en),
    .i_WrAddr   (wr_addr),
    .i_WrData   (wr_data),
    .i_Len      (len),
    .i_Loop     (loop_en),
    .i_Start    (start),
    .i_Stop     (stop),
`ifdef SEQ_SINGLE_STEP_EN
    .i_StepMode (step_mode),
    .i_Step     (step),
`endif
    .o_ALUSrc   (alusrc),
    .o_AddSub   (addsub),
    .o_RA0      (ra0),
    .o_RA1      (ra1),
    .o_WA       (wa),
    .o_Im       (im),
    .o_Valid    (valid),
    .o_Busy     (busy),
    .o_Done     (done),
    .o_Pass     (pass),
    .o_WrErr    (wrerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic exp_valid, input logic [32:0] exp_word);
    chk({tag, ".valid"}, 64'(valid), 64'(exp_valid));
    chk({tag, ".word"}, 64'({alusrc, addsub, ra0, ra1, wa, im}), 64'(exp_word));
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [32:0] data);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
    mdl_mem[addr] = data;
  endtask

  // Start a program and check `cycles` issued words against the model.
  task automatic run_check(input string tag, input int len_in, input bit lp, input int cycles);
    int eff_len;
    int exp_pass;
    eff_len = (len_in > Depth) ? Depth : len_in;
    len = 5'(len_in); loop_en = lp; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out({tag, ".lat"}, 1'b0, 33'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    for (int k = 1; k <= cycles; k++) begin
      tick();
      exp_pass = k / eff_len;
      if (exp_pass > 255) exp_pass = 255;
      chk_out(tag, 1'b1, mdl_mem[(k - 1) % eff_len]);
      chk({tag, ".pass"}, 64'(pass), 64'(exp_pass));
    end
  endtask

  task automatic expect_done(input string tag, input int exp_pass);
    tick();
    chk_out(tag, 1'b0, 33'd0);
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".pass"}, 64'(pass), 64'(exp_pass));
  endtask

  task automatic do_stop(input string tag, input int exp_pass);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out(tag, 1'b0, 33'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".pass"}, 64'(pass), 64'(exp_pass));
  endtask

  initial begin
    int wrerr_cnt;
    int rl;
    int rc;
    bit rlp;
    logic [32:0] orig0;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0;
    loop_en = 1'b0; start = 1'b0; stop = 1'b0; step_mode = 1'b0; step = 1'b0;
    #12;
    chk_out("reset", 1'b0, 33'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.pass", 64'(pass), 64'd0);
    chk("reset.wrerr", 64'(wrerr), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < Depth; i++) write_word(i, {1'($urandom), 32'($urandom)});
    for (int i = 0; i < 4; i++)
      write_word(i, {2'b00, 5'd0, 5'd0, 5'(i + 1), 16'(16 * (i + 1))});

    // Single pass of four words.
    run_check("single", 4, 1'b0, 4);
    expect_done("single.end", 1);
    tick();
    chk("single.sticky", 64'(done), 64'd1);

    // Loop of two words, then stop.
    run_check("loop", 2, 1'b1, 7);
    do_stop("loop.stop", 3);

    // Zero length and start+stop are both ignored.
    len = 5'd0; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("len0.busy", 64'(busy), 64'd0);
    chk("len0.valid", 64'(valid), 64'd0);
    len = 5'd4; start = 1'b1; stop = 1'b1;
    tick(); tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop.busy", 64'(busy), 64'd0);
    chk("startstop.valid", 64'(valid), 64'd0);

    // Oversized length clamps to the full depth.
    run_check("len20", 20, 1'b0, 16);
    expect_done("len20.end", 1);

    // Write during RUN is rejected and flagged once.
    orig0 = mdl_mem[0];
    wrerr_cnt = 0;
    len = 5'd4; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = ~orig0;
    tick();
    wr_en = 1'b0;
    chk("wrerr.pulse", 64'(wrerr), 64'd1);
    for (int k = 0; k < 6; k++) begin
      if (wrerr) wrerr_cnt++;
      tick();
    end
    chk("wrerr.count", 64'(wrerr_cnt), 64'd1);
    run_check("wrerr.rerun", 1, 1'b0, 1);
    chk("wrerr.word0", 64'({alusrc, addsub, ra0, ra1, wa, im}), 64'(orig0));
    expect_done("wrerr.end", 1);

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      rl  = $urandom_range(1, 20);
      rlp = 1'($urandom);
      rc  = rlp ? $urandom_range(1, 40) : ((rl > Depth) ? Depth : rl);
      run_check("rand", rl, rlp, rc);
      if (rlp) do_stop("rand.stop", rc / ((rl > Depth) ? Depth : rl));
      else     expect_done("rand.end", 1);
    end

    // Pass counter saturation.
    run_check("sat", 1, 1'b1, 300);
    chk("sat.pass", 64'(pass), 64'd255);
    do_stop("sat.stop", 255);

    // Asynchronous reset with three words issued.
    run_check("rstmid", 8, 1'b0, 3);
    #2;
    rst = 1'b1;
    #1;
    chk_out("rstmid.async", 1'b0, 33'd0);
    chk("rstmid.busy", 64'(busy), 64'd0);
    chk("rstmid.pass", 64'(pass), 64'd0);
    chk("rstmid.done", 64'(done), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid.idle", 64'(busy), 64'd0);
    chk("rstmid.valid", 64'(valid), 64'd0);

`ifdef SEQ_SINGLE_STEP_EN
    // Step mode: three rising edges issue exactly three words.
    step_mode = 1'b1;
    run_check("step", 8, 1'b0, 0);
    tick(); tick();
    chk("step.idle_valid", 64'(valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      chk_out("step.adv", 1'b1, mdl_mem[k]);
      step = 1'b0;
      tick();
      chk_out("step.hold", 1'b0, mdl_mem[k]);
    end
    tick();
    chk("step.busy", 64'(busy), 64'd1);
    do_stop("step.stop", 0);
    step_mode = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
